// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter with a one-entry holding buffer.
//
// Sends 8N1-style frames: one start bit (0), DATA_BITS data bits LSB first,
// STOP_BITS stop bits (1), no parity. Each bit lasts one baud period, and
// the line only changes on a CLKIN edge where the baud strobe is high.
// A byte can be accepted while a frame is in flight; it waits in the
// holding buffer. When the current frame's last stop period ends, the
// buffered byte starts immediately, with no idle gap.
//
// Parameters
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop-bit periods per frame (1 or 2)
//
// Ports
//   CLKIN   in   clock, all state changes on its rising edge
//   RESET   in   synchronous active-high reset
//   baud    in   one-cycle strobe per bit period
//   data    in   byte to send, sampled on an accept cycle (valid && ready)
//   valid   in   producer has a byte on data
//   ready   out  holding buffer empty
//   tx      out  registered serial line, idles high
//   busy    out  frame in progress (FSM not idle)
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    // DATA_BITS >= 5, so BIT_W >= 3 and always holds DATA_BITS-1.
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int STP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q,    state_nxt;
    logic                 tx_q,       tx_nxt;
    logic                 buf_full_q, buf_full_nxt;
    logic [DATA_BITS-1:0] buf_data_q, buf_data_nxt;
    logic [DATA_BITS-1:0] shreg_q,    shreg_nxt;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_nxt;
    logic [STP_W-1:0]     stop_cnt_q, stop_cnt_nxt;
    logic                 load;

    always_comb begin
        state_nxt    = state_q;
        tx_nxt       = tx_q;
        buf_full_nxt = buf_full_q;
        buf_data_nxt = buf_data_q;
        shreg_nxt    = shreg_q;
        bit_cnt_nxt  = bit_cnt_q;
        stop_cnt_nxt = stop_cnt_q;
        load         = 1'b0;

        // An accept needs an empty buffer and a drain needs a full one, so
        // the two can never hit the same edge.
        if (valid && !buf_full_q) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = data;
        end

        if (baud) begin
            case (state_q)
                S_IDLE: begin
                    if (buf_full_q) begin
                        load = 1'b1;
                    end
                end
                S_START: begin
                    tx_nxt      = shreg_q[0];
                    shreg_nxt   = shreg_q >> 1;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = '0;
                        state_nxt    = S_STOP;
                    end else begin
                        tx_nxt      = shreg_q[0];
                        shreg_nxt   = shreg_q >> 1;
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_cnt_q != STP_LAST) begin
                        stop_cnt_nxt = stop_cnt_q + 1'b1;
                    end else if (buf_full_q) begin
                        // back-to-back: next start bit replaces the idle period
                        load = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    tx_nxt    = 1'b1;
                end
            endcase
        end

        if (load) begin
            shreg_nxt    = buf_data_q;
            buf_full_nxt = 1'b0;
            tx_nxt       = 1'b0;
            state_nxt    = S_START;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            tx_q       <= tx_nxt;
            buf_full_q <= buf_full_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            stop_cnt_q <= stop_cnt_nxt;
        end
    end

    // Payload registers carry no reset; buf_full_q and the FSM guard them.
    always_ff @(posedge CLKIN) begin
        buf_data_q <= buf_data_nxt;
        shreg_q    <= shreg_nxt;
    end

    assign tx    = tx_q;
    assign ready = !buf_full_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two instances share one stimulus stream: 8 data / 1 stop and
// 7 data / 2 stop. A frame-level reference model tracks each instance. The
// model keeps the pending byte and the frame being sent as a bit vector
// with a count of periods remaining. The baud strobe fires every 4th
// CLKIN cycle unless it is paused.
module tb_uart_tx;

    logic       CLKIN = 1'b0;
    logic       RESET = 1'b1;
    logic       baud  = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       tx8, ready8, busy8;
    logic       tx7, ready7, busy7;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut8 (
        .CLKIN(CLKIN), .RESET(RESET), .baud(baud), .data(data),
        .valid(valid), .ready(ready8), .tx(tx8), .busy(busy8)
    );

    uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
        .CLKIN(CLKIN), .RESET(RESET), .baud(baud), .data(data[6:0]),
        .valid(valid), .ready(ready7), .tx(tx7), .busy(busy7)
    );

    always #5 CLKIN = ~CLKIN;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit baud_en = 1'b1;

    // reference model, index 0 = 8N1 instance, index 1 = 7N2 instance
    int         nb[2] = '{8, 7};
    int         ns[2] = '{1, 2};
    logic [15:0] fr[2];
    int         flen[2];
    int         rem[2];
    logic       mfull[2];
    logic [7:0] mbuf[2];

    // line value captured after every baud strobe
    logic log8[$];
    logic log7[$];

    logic e55[10]   = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    logic e41_8[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};
    logic e41_7[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    logic ea30f[20] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,
                        1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_tx(input int i);
        if (rem[i] > 0) return fr[i][flen[i] - rem[i]];
        return 1'b1;
    endfunction

    task automatic model_edge(input int i, input logic v, input logic [7:0] d,
                              input logic r, input logic b);
        logic acc;
        if (r) begin
            rem[i]   = 0;
            mfull[i] = 1'b0;
        end else begin
            acc = v && !mfull[i];
            if (b) begin
                if (rem[i] > 0) rem[i]--;
                if (rem[i] == 0 && mfull[i]) begin
                    fr[i]   = '0;
                    flen[i] = 1 + nb[i] + ns[i];
                    for (int k = 0; k < nb[i]; k++) fr[i][1 + k] = mbuf[i][k];
                    for (int s = 0; s < ns[i]; s++) fr[i][1 + nb[i] + s] = 1'b1;
                    rem[i]   = flen[i];
                    mfull[i] = 1'b0;
                end
            end
            if (acc) begin
                mbuf[i]  = d & 8'((1 << nb[i]) - 1);
                mfull[i] = 1'b1;
            end
        end
    endtask

    // one CLKIN cycle: drive inputs, advance model at the edge, check on negedge
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic b;
        b     = baud_en && (cyc % 4 == 3);
        valid = v;
        data  = d;
        RESET = r;
        baud  = b;
        @(posedge CLKIN);
        model_edge(0, v, d, r, b);
        model_edge(1, v, d, r, b);
        cyc++;
        @(negedge CLKIN);
        chk("tx8",    tx8,    exp_tx(0));
        chk("busy8",  busy8,  rem[0] > 0);
        chk("ready8", ready8, !mfull[0]);
        chk("tx7",    tx7,    exp_tx(1));
        chk("busy7",  busy7,  rem[1] > 0);
        chk("ready7", ready7, !mfull[1]);
        if (b) begin
            log8.push_back(tx8);
            log7.push_back(tx7);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_logs();
        log8.delete();
        log7.delete();
    endtask

    task automatic wait_bauds(input int n);
        int guard = 0;
        while (log8.size() < n && guard < 400) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("wait_bauds", log8.size() >= n, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rem[i]   = 0;
            mfull[i] = 1'b0;
            fr[i]    = '0;
            flen[i]  = 0;
            mbuf[i]  = '0;
        end

        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("rst_tx",    tx8,    1'b1);
        chk("rst_ready", ready8, 1'b1);
        chk("rst_busy",  busy8,  1'b0);
        idle(4);

        // single 0x55 frame
        step(1'b1, 8'h55, 1'b0);
        chk("acc55_ready", ready8, 1'b0);
        clear_logs();
        wait_bauds(11);
        if (log8.size() >= 10)
            for (int k = 0; k < 10; k++) chk($sformatf("f55_%0d", k), log8[k], e55[k]);
        chk("f55_busy_end", busy8, 1'b0);
        idle(60);

        // 0x41 on both widths (7N2 frame carries two stop periods)
        step(1'b1, 8'h41, 1'b0);
        clear_logs();
        wait_bauds(12);
        if (log8.size() >= 10)
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("f41_8_%0d", k), log8[k], e41_8[k]);
                chk($sformatf("f41_7_%0d", k), log7[k], e41_7[k]);
            end
        idle(60);

        // back-to-back: 0x0F accepted during 0xA3 data bits
        step(1'b1, 8'hA3, 1'b0);
        clear_logs();
        wait_bauds(3);
        step(1'b1, 8'h0F, 1'b0);
        chk("b2b_ready_low", ready8, 1'b0);
        wait_bauds(21);
        if (log8.size() >= 20)
            for (int k = 0; k < 20; k++) chk($sformatf("b2b_%0d", k), log8[k], ea30f[k]);
        idle(80);

        // valid held with buffer full, data changing every cycle
        for (int k = 0; k < 200; k++) step(1'b1, 8'($urandom), 1'b0);
        idle(100);

        // reset during data bit 3 of 0xFF with a byte buffered
        step(1'b1, 8'hFF, 1'b0);
        clear_logs();
        wait_bauds(5);
        step(1'b1, 8'h5A, 1'b0);
        chk("abort_buf_full", ready8, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("abort_tx",    tx8,    1'b1);
        chk("abort_busy",  busy8,  1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("abort_ready", ready8, 1'b1);
        clear_logs();
        idle(60);
        for (int k = 0; k < log8.size(); k++) chk($sformatf("no_resend_%0d", k), log8[k], 1'b1);
        chk("abort_idle_busy", busy8, 1'b0);

        // baud paused after an accept: buffer waits, frame starts on next strobe
        baud_en = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        idle(100);
        chk("hold_ready", ready8, 1'b0);
        chk("hold_tx",    tx8,    1'b1);
        chk("hold_busy",  busy8,  1'b0);
        baud_en = 1'b1;
        clear_logs();
        wait_bauds(1);
        if (log8.size() >= 1) chk("late_start", log8[0], 1'b0);
        chk("late_busy", busy8, 1'b1);
        idle(80);

        // random traffic with occasional resets
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 599) == 0);
        idle(80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001: Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-002: Parameter STOP_BITS, default 1, stop-bit periods per frame; legal values 1 or 2.
REQ-003: CLKIN  input  1  sole clock; all state changes on its rising edge.
REQ-004: RESET  input  1  reset, synchronous, active-high.
REQ-005: baud  input  1  one-cycle baud strobe from the baud generator; high for one CLKIN cycle per bit period.
REQ-006: data  input  DATA_BITS  byte to send; sampled only on an accept cycle.
REQ-007: valid  input  1  producer has a byte on data.
REQ-008: ready  output  1  one-entry holding buffer empty; byte accepted when valid && ready.
REQ-009: tx  output  1  serial line, registered; idle level 1.
REQ-010: busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-011: Frame format SHALL be: 1 start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop bits (1), no parity.
REQ-012: Each bit SHALL occupy exactly one baud period; tx SHALL change only on a CLKIN edge where baud=1, or on reset.
REQ-013: Accept: when valid && ready, the holding buffer SHALL capture data and set buf_full on the same edge; ready SHALL equal !buf_full (combinational); valid with ready=0 SHALL be ignored.
REQ-014: FSM states SHALL be IDLE, START, DATA, STOP; baud=0 cycles SHALL hold state, tx, and counters.
REQ-015: IDLE, baud=1, buf_full=1 -> shift register loads buffer; buf_full clears; tx<=0; go to START.
REQ-016: IDLE, baud=1, buf_full=0 -> stay IDLE; tx stays 1.
REQ-017: START, baud=1 -> tx<=bit 0; shift right; bit count<=0; go to DATA.
REQ-018: DATA, baud=1, count<DATA_BITS-1 -> tx<=next bit; count++; stay in DATA.
REQ-019: DATA, baud=1, count=DATA_BITS-1 -> tx<=1; stop count<=0; go to STOP.
REQ-020: STOP, baud=1, stop count<STOP_BITS-1 -> stop count++; tx stays 1.
REQ-021: STOP, baud=1, last stop period, buf_full=1 -> reload per REQ-015 and go to START (back-to-back frames, no idle gap).
REQ-022: STOP, baud=1, last stop period, buf_full=0 -> go to IDLE; tx stays 1.
REQ-023: Accept and buffer drain SHALL never coincide; ready is low while buf_full=1, and ready rises the cycle after the drain edge.
REQ-024: A byte accepted during a frame SHALL wait in the buffer without disturbing the frame in progress.
REQ-025: Frame latency SHALL be: first tx=0 on the first baud strobe at or after the cycle following the accept edge when idle.
REQ-026: Counters SHALL be sized to hold DATA_BITS-1 and STOP_BITS-1 without wrap; no arithmetic overflow shall be possible.

Reset
REQ-027: RESET=1 SHALL force, at the next edge: state IDLE, tx=1, buf_full=0 (ready=1 once RESET falls), busy=0, counters=0.
REQ-028: RESET SHALL take priority over baud and valid; an accept presented with RESET=1 SHALL be discarded.
REQ-029: Reset mid-frame SHALL abort the frame (tx=1 at the next edge) and discard any buffered byte; no partial resend.

Verification (bench baud strobe every 4 CLKIN cycles, defaults unless noted)
REQ-030: Reset, then valid=1 with data=0x55 for one cycle -> ready drops; tx over 10 baud periods = 0,1,0,1,0,1,0,1,0,1; busy high from START through STOP; then tx=1, busy=0.
REQ-031: Accept 0xA3, then accept 0x0F during its data bits -> ready=0 until the 0xA3 STOP ends; 0x0F start bit begins on the baud strobe that ends the 0xA3 stop bit, with no extra idle period.
REQ-032: valid held high with ready=0 and data varying -> buffer keeps the first accepted value; only the accepted bytes appear on tx.
REQ-033: RESET pulsed during data bit 3 of 0xFF with a byte buffered -> tx=1 the next cycle, busy=0, ready=1 after RESET falls, and no further frame without a new accept.
REQ-034: STOP_BITS=2, DATA_BITS=7, send 0x41 -> tx = 0,1,0,0,0,0,0,1,1,1 over 10 periods.
REQ-035: baud held 0 for 100 cycles after an accept -> tx stays 1, state IDLE, buffer retained; frame starts on the first subsequent strobe.
